// File: rtl/seq_addsub.sv
// seq_addsub -- multi-cycle adder/subtractor.
//
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock, least
// significant chunk first, with the inter-chunk carry held in a register.
// An operation takes N = WIDTH/CHUNK RUN cycles plus one DONE cycle.
//
// Handshake: start is accepted only on an edge where ready=1 (IDLE). done
// pulses high for exactly one cycle once s/cout/ovf/zero are updated. A start
// seen while ready=0 is dropped; there is no queuing. Result outputs hold
// their value until the next operation completes.
//
// Optional build macro: SEQ_ADDSUB_SAT_EN -- when defined, s saturates to the
// signed limit on overflow (ovf/cout still report the raw result).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      operation request (accepted when ready=1)
//   sub        0: a+b+cin, 1: a-b-cin (cin is borrow-in)
//   a, b       operands, sampled at the accepting edge
//   cin        carry/borrow-in, sampled at the accepting edge
//   ready      high in IDLE
//   busy       high in RUN
//   done       one-cycle completion pulse
//   s          registered result
//   cout       carry out of MSB (sub mode: 1 = no borrow)
//   ovf        signed overflow
//   zero       s == 0
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;        // shifted right one chunk per RUN cycle
  logic [WIDTH-1:0] r_b;        // holds b or ~b, shifted like r_a
  logic             r_c;        // carry between chunks
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_partial;  // finished chunks enter from the top
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_partial_next;
  logic             w_last;
  logic             w_cmsb;
  logic             w_ovf;
  logic [WIDTH-1:0] w_s_next;

  // The current chunk of each operand always sits in the low CHUNK bits.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_c};

  generate
    if (N > 1) begin : g_multi
      assign w_partial_next = {w_sum[CHUNK-1:0], r_partial[WIDTH-1:CHUNK]};
    end else begin : g_single
      assign w_partial_next = w_sum[CHUNK-1:0];
    end
  endgenerate

  assign w_last = (r_idx == IDXW'(N - 1));

  // On the last chunk, the sum bit at the MSB is a^b^carry_in, so the carry
  // into the MSB can be recovered from the sum without a second adder.
  assign w_cmsb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];
  assign w_ovf  = w_cmsb ^ w_sum[CHUNK];

`ifdef SEQ_ADDSUB_SAT_EN
  // With overflow both effective operands share a sign; that sign picks the limit.
  assign w_s_next = w_ovf ? (r_a[CHUNK-1] ? SAT_NEG : SAT_POS) : w_partial_next;
`else
  assign w_s_next = w_partial_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= 1'b0;
      r_idx     <= '0;
      r_partial <= '0;
      r_s       <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= sub ? ~b : b;
            r_c       <= cin ^ sub;
            r_idx     <= '0;
            r_partial <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_a       <= r_a >> CHUNK;
          r_b       <= r_b >> CHUNK;
          r_c       <= w_sum[CHUNK];
          r_partial <= w_partial_next;
          r_idx     <= r_idx + IDXW'(1);
          if (w_last) begin
            r_s     <= w_s_next;
            r_cout  <= w_sum[CHUNK];
            r_ovf   <= w_ovf;
            r_zero  <= (w_s_next == '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule
